// File: rtl/mirfak_csr_arbiter.sv
// Arbitrates the core's single CSR access port between the WB pipeline (port 0) and debug/host (port 1).
// Define MIRFAK_CSR_ARB_RR_EN for round-robin arbitration; otherwise fixed priority with a starvation guard.
module mirfak_csr_arbiter #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        p0_valid_i,
   input  logic [11:0] p0_addr_i,
   input  logic [1:0]  p0_cmd_i,
   input  logic        p0_rs1_zero_i,
   input  logic [31:0] p0_wdata_i,
   output logic        p0_ready_o,
   output logic        p0_rvalid_o,
   input  logic        p1_valid_i,
   input  logic [11:0] p1_addr_i,
   input  logic [1:0]  p1_cmd_i,
   input  logic        p1_rs1_zero_i,
   input  logic [31:0] p1_wdata_i,
   output logic        p1_ready_o,
   output logic        p1_rvalid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic [11:0] csr_addr_o,
   output logic [1:0]  csr_cmd_o,
   output logic        csr_rs1_zero_o,
   output logic [31:0] csr_wdata_o,
   input  logic [31:0] csr_rdata_i,
   input  logic        csr_exception_i,
   input  logic        wb_exception_i,
   input  logic        wb_xret_i
);
   // state | meaning
   // IDLE  | no request held; grant a valid port and latch its request
   // ISSUE | drive the latched access unless a trap entry or xRET retires
   // RESP  | one-cycle rvalid to the granted port
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   state_t      state;
   logic        gnt_port_q;
   logic [11:0] addr_q;
   logic [1:0]  cmd_q;
   logic        rs1_zero_q;
   logic [31:0] wdata_q;
   logic        any_valid;
   logic        tie;
   logic        win_port;
   logic        grant;
   logic        stall;
   logic        issue;
`ifdef MIRFAK_CSR_ARB_RR_EN
   logic        rr_ptr;
`else
   logic [3:0]  wait_cnt;
`endif

   assign any_valid = p0_valid_i | p1_valid_i;
   assign tie       = p0_valid_i & p1_valid_i;
`ifdef MIRFAK_CSR_ARB_RR_EN
   assign win_port  = tie ? rr_ptr : p1_valid_i;
`else
   assign win_port  = tie ? (wait_cnt >= 4'(MAX_WAIT)) : p1_valid_i;
`endif

   // ready is decoded in IDLE so the access lands one cycle after acceptance
   assign grant      = rst_i & (state == ST_IDLE) & any_valid;
   assign p0_ready_o = grant & ~win_port;
   assign p1_ready_o = grant & win_port;

   assign stall          = wb_exception_i | wb_xret_i;
   assign issue          = rst_i & (state == ST_ISSUE) & ~stall;
   assign csr_cmd_o      = issue ? cmd_q : 2'b00;
   assign csr_addr_o     = addr_q;
   assign csr_rs1_zero_o = rs1_zero_q;
   assign csr_wdata_o    = wdata_q;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state       <= ST_IDLE;
         gnt_port_q  <= 1'b0;
         addr_q      <= '0;
         cmd_q       <= '0;
         rs1_zero_q  <= 1'b0;
         wdata_q     <= '0;
         p0_rvalid_o <= 1'b0;
         p1_rvalid_o <= 1'b0;
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;
`ifdef MIRFAK_CSR_ARB_RR_EN
         rr_ptr      <= 1'b0;
`else
         wait_cnt    <= '0;
`endif
      end else begin
         p0_rvalid_o <= 1'b0;
         p1_rvalid_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (any_valid) begin
                  gnt_port_q <= win_port;
                  addr_q     <= win_port ? p1_addr_i     : p0_addr_i;
                  cmd_q      <= win_port ? p1_cmd_i      : p0_cmd_i;
                  rs1_zero_q <= win_port ? p1_rs1_zero_i : p0_rs1_zero_i;
                  wdata_q    <= win_port ? p1_wdata_i    : p0_wdata_i;
`ifdef MIRFAK_CSR_ARB_RR_EN
                  rr_ptr     <= ~win_port;
`else
                  if (win_port)
                     wait_cnt <= '0;
                  else if (p1_valid_i && (wait_cnt != 4'hF))
                     wait_cnt <= wait_cnt + 4'd1;
`endif
                  state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (!stall) begin
                  rsp_rdata_o <= csr_rdata_i;
                  rsp_err_o   <= csr_exception_i;
                  p0_rvalid_o <= ~gnt_port_q;
                  p1_rvalid_o <= gnt_port_q;
                  state       <= ST_RESP;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mirfak_csr_arbiter.sv
// Directed bench for mirfak_csr_arbiter: a transaction-level model checked every cycle, plus literal timing/data pins.
`timescale 1ns/1ps
module tb_mirfak_csr_arbiter;
   localparam int MAX_WAIT = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        p0_valid_i, p0_rs1_zero_i, p0_ready_o, p0_rvalid_o;
   logic [11:0] p0_addr_i;
   logic [1:0]  p0_cmd_i;
   logic [31:0] p0_wdata_i;
   logic        p1_valid_i, p1_rs1_zero_i, p1_ready_o, p1_rvalid_o;
   logic [11:0] p1_addr_i;
   logic [1:0]  p1_cmd_i;
   logic [31:0] p1_wdata_i;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic [11:0] csr_addr_o;
   logic [1:0]  csr_cmd_o;
   logic        csr_rs1_zero_o;
   logic [31:0] csr_wdata_o;
   logic [31:0] csr_rdata_i;
   logic        csr_exception_i;
   logic        wb_exception_i, wb_xret_i;

   mirfak_csr_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .p0_valid_i(p0_valid_i), .p0_addr_i(p0_addr_i), .p0_cmd_i(p0_cmd_i),
      .p0_rs1_zero_i(p0_rs1_zero_i), .p0_wdata_i(p0_wdata_i),
      .p0_ready_o(p0_ready_o), .p0_rvalid_o(p0_rvalid_o),
      .p1_valid_i(p1_valid_i), .p1_addr_i(p1_addr_i), .p1_cmd_i(p1_cmd_i),
      .p1_rs1_zero_i(p1_rs1_zero_i), .p1_wdata_i(p1_wdata_i),
      .p1_ready_o(p1_ready_o), .p1_rvalid_o(p1_rvalid_o),
      .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .csr_addr_o(csr_addr_o), .csr_cmd_o(csr_cmd_o),
      .csr_rs1_zero_o(csr_rs1_zero_o), .csr_wdata_o(csr_wdata_o),
      .csr_rdata_i(csr_rdata_i), .csr_exception_i(csr_exception_i),
      .wb_exception_i(wb_exception_i), .wb_xret_i(wb_xret_i)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   // CSR file stand-in: MISA is read-only, every other address reads a pattern
   function automatic logic [31:0] csr_val(input logic [11:0] a);
      case (a)
         12'h300: csr_val = 32'h0000_1880;
         12'h301: csr_val = 32'h4000_1104;
         12'h305: csr_val = 32'h8000_0000;
         default: csr_val = {20'hC5A00, a};
      endcase
   endfunction

   function automatic logic csr_illegal(input logic [11:0] a, input logic [1:0] c);
      csr_illegal = (a == 12'h301) && (c != 2'b00);
   endfunction

   always_comb begin
      csr_rdata_i     = csr_val(csr_addr_o);
      csr_exception_i = csr_illegal(csr_addr_o, csr_cmd_o);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s cyc=%0d actual=timeout expected=event", name, cyc);
   endtask

   // transaction-level model: one held request, one pending response
   logic        m_busy = 0, m_port = 0, m_resp = 0, m_resp_port = 0;
   logic [11:0] m_addr = '0;
   logic [1:0]  m_cmd = '0;
   logic        m_rs1z = 0;
   logic [31:0] m_wdata = '0, m_rdata = '0;
   logic        m_err = 0;
   int          m_waits = 0;
   logic        m_rr_next = 0;

   bit          grant_log[$];
   int          rv_count = 0, cmd_cyc = -1;
   logic [1:0]  last_cmd = '0;

   logic        c_any, c_tie, c_win, c_stall, c_free, c_resp_next;
   logic [1:0]  c_cmd;

   always @(negedge clk_i) begin
      c_any   = p0_valid_i | p1_valid_i;
      c_tie   = p0_valid_i & p1_valid_i;
      c_stall = wb_exception_i | wb_xret_i;
`ifdef MIRFAK_CSR_ARB_RR_EN
      c_win   = c_tie ? m_rr_next : p1_valid_i;
`else
      c_win   = c_tie ? (m_waits >= MAX_WAIT) : p1_valid_i;
`endif
      c_free  = !m_busy && !m_resp;
      c_cmd   = (rst_i && m_busy && !c_stall) ? m_cmd : 2'b00;

      check("p0_ready",  p0_ready_o,  rst_i && c_free && c_any && !c_win);
      check("p1_ready",  p1_ready_o,  rst_i && c_free && c_any && c_win);
      check("csr_cmd",   csr_cmd_o,   c_cmd);
      check("csr_addr",  csr_addr_o,  m_addr);
      check("csr_wdata", csr_wdata_o, m_wdata);
      check("csr_rs1z",  csr_rs1_zero_o, m_rs1z);
      check("p0_rvalid", p0_rvalid_o, m_resp && !m_resp_port);
      check("p1_rvalid", p1_rvalid_o, m_resp && m_resp_port);
      check("rsp_rdata", rsp_rdata_o, m_rdata);
      check("rsp_err",   rsp_err_o,   m_err);

      if (p0_ready_o) grant_log.push_back(1'b0);
      if (p1_ready_o) grant_log.push_back(1'b1);
      if (p0_rvalid_o || p1_rvalid_o) rv_count++;
      if (csr_cmd_o != 2'b00) begin
         cmd_cyc  = cyc;
         last_cmd = csr_cmd_o;
      end

      if (!rst_i) begin
         m_busy = 0; m_port = 0; m_resp = 0; m_resp_port = 0;
         m_addr = '0; m_cmd = '0; m_rs1z = 0; m_wdata = '0;
         m_rdata = '0; m_err = 0; m_waits = 0; m_rr_next = 0;
      end else begin
         c_resp_next = 1'b0;
         if (c_free && c_any) begin
            m_busy  = 1;
            m_port  = c_win;
            m_addr  = c_win ? p1_addr_i     : p0_addr_i;
            m_cmd   = c_win ? p1_cmd_i      : p0_cmd_i;
            m_rs1z  = c_win ? p1_rs1_zero_i : p0_rs1_zero_i;
            m_wdata = c_win ? p1_wdata_i    : p0_wdata_i;
            m_rr_next = !c_win;
            if (c_win) m_waits = 0;
            else if (p1_valid_i && m_waits < 15) m_waits = m_waits + 1;
         end else if (m_busy && !c_stall) begin
            m_rdata     = csr_val(m_addr);
            m_err       = csr_illegal(m_addr, m_cmd);
            m_resp_port = m_port;
            m_busy      = 0;
            c_resp_next = 1'b1;
         end
         m_resp = c_resp_next;
      end
   end

   task automatic req(input bit port, input logic [11:0] a, input logic [1:0] c, input logic rz,
                      input logic [31:0] wd, input int nstall, input bit poke,
                      output int t_start, output int t_rdy, output int t_rv);
      t_rdy = -1;
      t_rv  = -1;
      if (port) begin
         p1_valid_i = 1; p1_addr_i = a; p1_cmd_i = c; p1_rs1_zero_i = rz; p1_wdata_i = wd;
      end else begin
         p0_valid_i = 1; p0_addr_i = a; p0_cmd_i = c; p0_rs1_zero_i = rz; p0_wdata_i = wd;
      end
      t_start = cyc;
      for (int i = 0; i < 20 && t_rdy < 0; i++) begin
         @(negedge clk_i);
         if (port ? p1_ready_o : p0_ready_o) t_rdy = cyc;
      end
      if (t_rdy < 0) timeout("ready_wait");
      @(posedge clk_i); #1;
      p0_valid_i = 0;
      p1_valid_i = 0;
      if (nstall > 0) begin
         wb_xret_i = 1;
         repeat (nstall) @(posedge clk_i);
         #1;
         wb_xret_i = 0;
      end
      if (poke) begin
         if (port) p0_valid_i = 1; else p1_valid_i = 1;
         @(posedge clk_i); #1;
         p0_valid_i = 0;
         p1_valid_i = 0;
      end
      for (int i = 0; i < 20 && t_rv < 0; i++) begin
         @(negedge clk_i);
         if (port ? p1_rvalid_o : p0_rvalid_o) t_rv = cyc;
      end
      if (t_rv < 0) timeout("rvalid_wait");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
      $fatal(1, "watchdog");
   end

   int  ts, tr, tv, rv0, g0, got;
   bit  exp_order[10];

   initial begin
      rst_i = 0;
      p0_valid_i = 0; p0_addr_i = '0; p0_cmd_i = '0; p0_rs1_zero_i = 0; p0_wdata_i = '0;
      p1_valid_i = 0; p1_addr_i = '0; p1_cmd_i = '0; p1_rs1_zero_i = 0; p1_wdata_i = '0;
      wb_exception_i = 0; wb_xret_i = 0;
      repeat (2) @(posedge clk_i);
      #1;
      check("reset_rdata", rsp_rdata_o, 32'h0);
      check("reset_addr",  csr_addr_o,  12'h0);
      rst_i = 1;
      repeat (2) @(posedge clk_i);
      #1;

      // mstatus read: ready N, rvalid N+2
      req(1'b0, 12'h300, 2'b00, 1'b1, 32'h0, 0, 1'b0, ts, tr, tv);
      check("mstatus_latency", tv - tr, 2);
      check("mstatus_rdata", rsp_rdata_o, 32'h0000_1880);
      check("mstatus_err", rsp_err_o, 1'b0);
      @(posedge clk_i); #1;

      // MISA write is illegal
      req(1'b0, 12'h301, 2'b01, 1'b0, 32'h0000_0005, 0, 1'b0, ts, tr, tv);
      check("misa_err", rsp_err_o, 1'b1);
      check("misa_rdata", rsp_rdata_o, 32'h4000_1104);
      @(posedge clk_i); #1;

      // mtvec write with an xRET retiring the cycle after ready
      req(1'b1, 12'h305, 2'b01, 1'b0, 32'h8000_0100, 1, 1'b0, ts, tr, tv);
      check("mtvec_cmd_cycle", cmd_cyc - tr, 2);
      check("mtvec_cmd", last_cmd, 2'b01);
      check("mtvec_rvalid_cycle", tv - tr, 3);
      check("mtvec_wdata_hold", csr_wdata_o, 32'h8000_0100);
      @(posedge clk_i); #1;

      // reset while the request is in ISSUE drops it
      rv0 = rv_count;
      p0_valid_i = 1; p0_addr_i = 12'h340; p0_cmd_i = 2'b10; p0_rs1_zero_i = 0; p0_wdata_i = 32'h0000_00FF;
      tr = -1;
      for (int i = 0; i < 20 && tr < 0; i++) begin
         @(negedge clk_i);
         if (p0_ready_o) tr = cyc;
      end
      if (tr < 0) timeout("reset_ready_wait");
      @(posedge clk_i); #1;
      p0_valid_i = 0;
      rst_i = 0;
      @(negedge clk_i);
      check("rst_issue_cmd", csr_cmd_o, 2'b00);
      @(posedge clk_i); #1;
      rst_i = 1;
      repeat (4) @(negedge clk_i);
      check("rst_no_rvalid", rv_count - rv0, 0);
      check("rst_rdata_zero", rsp_rdata_o, 32'h0);
      check("rst_wdata_zero", csr_wdata_o, 32'h0);
      @(posedge clk_i); #1;

      // single p1 request from IDLE, with a p0 valid that drops before ready
      g0 = grant_log.size();
      req(1'b1, 12'h7B0, 2'b11, 1'b1, 32'h0000_0003, 0, 1'b1, ts, tr, tv);
      check("p1_single_ready_cycle", tr - ts, 0);
      check("p1_single_rdata", rsp_rdata_o, 32'hC5A0_07B0);
      repeat (3) @(negedge clk_i);
      check("dropped_valid_ignored", grant_log.size() - g0, 1);
      @(posedge clk_i); #1;

      // both ports held valid
`ifdef MIRFAK_CSR_ARB_RR_EN
      exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
      g0 = grant_log.size();
      p0_valid_i = 1; p0_addr_i = 12'h341; p0_cmd_i = 2'b10; p0_rs1_zero_i = 1; p0_wdata_i = 32'h1234_5678;
      p1_valid_i = 1; p1_addr_i = 12'h7B1; p1_cmd_i = 2'b11; p1_rs1_zero_i = 0; p1_wdata_i = 32'hDEAD_BEEF;
      for (int i = 0; i < 80 && grant_log.size() < g0 + 10; i++) @(negedge clk_i);
      @(posedge clk_i); #1;
      p0_valid_i = 0;
      p1_valid_i = 0;
      got = grant_log.size() - g0;
      if (got < 10) timeout("arb_grants");
      for (int i = 0; i < 10 && i < got; i++)
         check($sformatf("grant_order[%0d]", i), grant_log[g0 + i], exp_order[i]);
      repeat (4) @(negedge clk_i);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
